// File: rtl/cu_sequencer_if.sv
// Handshake and strobe bundle between the multicycle sequencer and the
// decoder / datapath / RAM side.
interface cu_sequencer_if;
    logic       run;
    logic       halt_req;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       dec_reg_wr;
    logic       dec_flag_wr;
    logic [1:0] dec_pc_sel;

    logic       IL;
    logic       EN_ADDR_PC;
    logic       EN_ADDR_ALU;
    logic       RCS;
    logic       RR;
    logic       WRR;
    logic       EN_ALU;
    logic       WR;
    logic       SFL;
    logic       PC_LD;
    logic [1:0] PC_SEL;

    modport master (
        input  run, halt_req, dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_flag_wr, dec_pc_sel,
        output IL, EN_ADDR_PC, EN_ADDR_ALU, RCS, RR, WRR, EN_ALU, WR, SFL, PC_LD, PC_SEL
    );

    modport slave (
        output run, halt_req, dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_flag_wr, dec_pc_sel,
        input  IL, EN_ADDR_PC, EN_ADDR_ALU, RCS, RR, WRR, EN_ALU, WR, SFL, PC_LD, PC_SEL
    );
endinterface

// File: rtl/cu_sequencer.sv
// Multicycle LEGv8 sequencer: fetch, decode, execute, optional memory, writeback.
// Strobes are Moore outputs of the state register and the control bits latched at DECODE.
module cu_sequencer #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    cu_sequencer_if.master   bus,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    // A wait of 0 behaves as 1; the 4-bit wait counter caps it at 15.
    localparam int         MW        = (MEM_WAIT < 1) ? 1 : ((MEM_WAIT > 15) ? 15 : MEM_WAIT);
    localparam logic [3:0] WAIT_LAST = 4'(MW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             reg_wr_q, reg_wr_d;
    logic             flag_wr_q, flag_wr_d;
    logic [1:0]       pc_sel_q, pc_sel_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_last;

    assign wait_last = (wait_q == WAIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH:  if (wait_last) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (mem_rd_q || mem_wr_q) ? S_MEM : S_WB;
            S_MEM:    if (wait_last) state_d = S_WB;
            S_WB: begin
                if (halt_q)       state_d = S_HALT;
                else if (!bus.run) state_d = S_IDLE;
                else              state_d = S_FETCH;
            end
            S_HALT:   if (!bus.run) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.IL          = 1'b0;
        bus.EN_ADDR_PC  = 1'b0;
        bus.EN_ADDR_ALU = 1'b0;
        bus.RCS         = 1'b0;
        bus.RR          = 1'b0;
        bus.WRR         = 1'b0;
        bus.EN_ALU      = 1'b0;
        bus.WR          = 1'b0;
        bus.SFL         = 1'b0;
        bus.PC_LD       = 1'b0;
        bus.PC_SEL      = 2'b00;
        halted          = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.RCS        = 1'b1;
                bus.RR         = 1'b1;
                bus.EN_ADDR_PC = 1'b1;
                bus.IL         = wait_last;
            end
            S_EXEC: bus.EN_ALU = 1'b1;
            S_MEM: begin
                bus.RCS         = 1'b1;
                bus.EN_ADDR_ALU = 1'b1;
                bus.EN_ALU      = 1'b1;
                bus.WRR         = mem_wr_q;
                bus.RR          = mem_rd_q & ~mem_wr_q;
            end
            S_WB: begin
                bus.WR     = reg_wr_q & ~mem_wr_q;
                bus.SFL    = flag_wr_q;
                bus.PC_SEL = pc_sel_q;
                bus.PC_LD  = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // Counter returns to 0 on every exit, so FETCH and MEM always start from 0.
    always_comb begin
        wait_d    = 4'd0;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        reg_wr_d  = reg_wr_q;
        flag_wr_d = flag_wr_q;
        pc_sel_d  = pc_sel_q;
        cnt_d     = cnt_q;
        if ((state_q == S_FETCH || state_q == S_MEM) && !wait_last)
            wait_d = wait_q + 4'd1;
        if (state_q == S_DECODE) begin
            mem_rd_d  = bus.dec_mem_rd;
            mem_wr_d  = bus.dec_mem_wr;
            reg_wr_d  = bus.dec_reg_wr;
            flag_wr_d = bus.dec_flag_wr;
            pc_sel_d  = bus.dec_pc_sel;
        end
        if (state_q == S_WB)
            cnt_d = cnt_q + 1'b1;
        halt_d = (state_d == S_HALT && state_q != S_HALT) ? 1'b0 : (halt_q | bus.halt_req);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_q    <= 4'd0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            reg_wr_q  <= 1'b0;
            flag_wr_q <= 1'b0;
            pc_sel_q  <= 2'b00;
            halt_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wait_q    <= wait_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            reg_wr_q  <= reg_wr_d;
            flag_wr_q <= flag_wr_d;
            pc_sel_q  <= pc_sel_d;
            halt_q    <= halt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: a per-cycle vector table on the default build,
// plus hand sequences for async reset in MEM and counter wrap with MEM_WAIT=1.
module tb_cu_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  state0, state1;
    logic        halted0, halted1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [12:0] out0, out1;
    int          total = 0;
    int          bad = 0;

    cu_sequencer_if bus0 ();
    cu_sequencer_if bus1 ();

    cu_sequencer #(.MEM_WAIT(2), .CNT_W(16)) u_dut0 (
        .clock(clock), .reset(reset), .bus(bus0),
        .state(state0), .halted(halted0), .instr_count(cnt0)
    );

    cu_sequencer #(.MEM_WAIT(1), .CNT_W(4)) u_dut1 (
        .clock(clock), .reset(reset), .bus(bus1),
        .state(state1), .halted(halted1), .instr_count(cnt1)
    );

    always #5 clock = ~clock;

    // {IL, EN_ADDR_PC, EN_ADDR_ALU, RCS, RR, WRR, EN_ALU, WR, SFL, PC_LD, PC_SEL[1:0], halted}
    assign out0 = {bus0.IL, bus0.EN_ADDR_PC, bus0.EN_ADDR_ALU, bus0.RCS, bus0.RR, bus0.WRR,
                   bus0.EN_ALU, bus0.WR, bus0.SFL, bus0.PC_LD, bus0.PC_SEL, halted0};
    assign out1 = {bus1.IL, bus1.EN_ADDR_PC, bus1.EN_ADDR_ALU, bus1.RCS, bus1.RR, bus1.WRR,
                   bus1.EN_ALU, bus1.WR, bus1.SFL, bus1.PC_LD, bus1.PC_SEL, halted1};

    localparam logic [12:0] O_NONE = 13'b0_0_0_0_0_0_0_0_0_0_00_0;
    localparam logic [12:0] O_F    = 13'b0_1_0_1_1_0_0_0_0_0_00_0;
    localparam logic [12:0] O_FL   = 13'b1_1_0_1_1_0_0_0_0_0_00_0;
    localparam logic [12:0] O_EX   = 13'b0_0_0_0_0_0_1_0_0_0_00_0;
    localparam logic [12:0] O_MR   = 13'b0_0_1_1_1_0_1_0_0_0_00_0;
    localparam logic [12:0] O_MW   = 13'b0_0_1_1_0_1_1_0_0_0_00_0;
    localparam logic [12:0] O_WALU = 13'b0_0_0_0_0_0_0_1_0_1_01_0;
    localparam logic [12:0] O_WST  = 13'b0_0_0_0_0_0_0_0_0_1_10_0;
    localparam logic [12:0] O_WFLG = 13'b0_0_0_0_0_0_0_1_1_1_11_0;
    localparam logic [12:0] O_H    = 13'b0_0_0_0_0_0_0_0_0_0_00_1;

    // {mem_rd, mem_wr, reg_wr, flag_wr, pc_sel[1:0]}
    localparam logic [5:0] D_NONE = 6'b0000_00;
    localparam logic [5:0] D_ALU  = 6'b0010_01;
    localparam logic [5:0] D_LD   = 6'b1010_01;
    localparam logic [5:0] D_ST   = 6'b1110_10;
    localparam logic [5:0] D_FLG  = 6'b0011_11;

    typedef struct {
        logic        run;
        logic        hreq;
        logic [5:0]  dec;
        logic [2:0]  st;
        logic [12:0] out;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic h, input logic [5:0] d,
                       input logic [2:0] s, input logic [12:0] o, input logic [15:0] c);
        vec_t v;
        v.run = r; v.hreq = h; v.dec = d; v.st = s; v.out = o; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive0(input logic r, input logic h, input logic [5:0] d);
        bus0.run = r;
        bus0.halt_req = h;
        {bus0.dec_mem_rd, bus0.dec_mem_wr, bus0.dec_reg_wr, bus0.dec_flag_wr, bus0.dec_pc_sel} = d;
    endtask

    logic [2:0] seq1[4];
    bit         found;

    initial begin
        drive0(1'b0, 1'b0, D_NONE);
        bus1.run = 1'b0;
        bus1.halt_req = 1'b0;
        {bus1.dec_mem_rd, bus1.dec_mem_wr, bus1.dec_reg_wr, bus1.dec_flag_wr, bus1.dec_pc_sel} = D_ALU;
        seq1[0] = 3'd1; seq1[1] = 3'd2; seq1[2] = 3'd3; seq1[3] = 3'd5;

        // ALU op, load, store (rd+wr+reg_wr), flag op with halt, run drop during FETCH
        add(1, 0, D_NONE, 3'd0, O_NONE, 16'd0);
        add(1, 0, D_ALU,  3'd1, O_F,    16'd0);
        add(1, 0, D_ALU,  3'd1, O_FL,   16'd0);
        add(1, 0, D_ALU,  3'd2, O_NONE, 16'd0);
        add(1, 0, D_ALU,  3'd3, O_EX,   16'd0);
        add(1, 0, D_ALU,  3'd5, O_WALU, 16'd0);
        add(1, 0, D_LD,   3'd1, O_F,    16'd1);
        add(1, 0, D_LD,   3'd1, O_FL,   16'd1);
        add(1, 0, D_LD,   3'd2, O_NONE, 16'd1);
        add(1, 0, D_NONE, 3'd3, O_EX,   16'd1);
        add(1, 0, D_NONE, 3'd4, O_MR,   16'd1);
        add(1, 0, D_NONE, 3'd4, O_MR,   16'd1);
        add(1, 0, D_NONE, 3'd5, O_WALU, 16'd1);
        add(1, 0, D_ST,   3'd1, O_F,    16'd2);
        add(1, 0, D_ST,   3'd1, O_FL,   16'd2);
        add(1, 0, D_ST,   3'd2, O_NONE, 16'd2);
        add(1, 0, D_NONE, 3'd3, O_EX,   16'd2);
        add(1, 0, D_NONE, 3'd4, O_MW,   16'd2);
        add(1, 0, D_NONE, 3'd4, O_MW,   16'd2);
        add(1, 0, D_NONE, 3'd5, O_WST,  16'd2);
        add(1, 0, D_FLG,  3'd1, O_F,    16'd3);
        add(1, 0, D_FLG,  3'd1, O_FL,   16'd3);
        add(1, 0, D_FLG,  3'd2, O_NONE, 16'd3);
        add(1, 1, D_NONE, 3'd3, O_EX,   16'd3);
        add(1, 0, D_NONE, 3'd5, O_WFLG, 16'd3);
        add(1, 0, D_NONE, 3'd6, O_H,    16'd4);
        add(0, 0, D_NONE, 3'd6, O_H,    16'd4);
        add(0, 0, D_NONE, 3'd0, O_NONE, 16'd4);
        add(1, 0, D_NONE, 3'd0, O_NONE, 16'd4);
        add(0, 0, D_ALU,  3'd1, O_F,    16'd4);
        add(0, 0, D_ALU,  3'd1, O_FL,   16'd4);
        add(0, 0, D_ALU,  3'd2, O_NONE, 16'd4);
        add(0, 0, D_NONE, 3'd3, O_EX,   16'd4);
        add(0, 0, D_NONE, 3'd5, O_WALU, 16'd4);
        add(0, 0, D_NONE, 3'd0, O_NONE, 16'd5);
        add(0, 0, D_NONE, 3'd0, O_NONE, 16'd5);

        repeat (2) @(negedge clock);
        check("reset_state", 32'(state0), 32'd0);
        check("reset_outputs", 32'(out0), 32'(O_NONE));
        check("reset_count", 32'(cnt0), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clock);
            #1;
            drive0(vecs[i].run, vecs[i].hreq, vecs[i].dec);
            @(negedge clock);
            check($sformatf("v%0d_state", i), 32'(state0), 32'(vecs[i].st));
            check($sformatf("v%0d_outs", i), 32'(out0), 32'(vecs[i].out));
            check($sformatf("v%0d_count", i), 32'(cnt0), 32'(vecs[i].cnt));
        end

        // Asynchronous reset while a store is in MEM
        found = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(posedge clock);
            #1;
            drive0(1'b1, 1'b0, D_ST);
            @(negedge clock);
            if (state0 == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_mem", 32'(found), 32'd1);
        check("mem_wrr_before_reset", 32'(bus0.WRR), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_wrr", 32'(bus0.WRR), 32'd0);
        check("async_rst_rcs", 32'(bus0.RCS), 32'd0);
        check("async_rst_state", 32'(state0), 32'd0);
        check("async_rst_count", 32'(cnt0), 32'd0);
        check("async_rst_outs", 32'(out0), 32'(O_NONE));
        drive0(1'b0, 1'b0, D_NONE);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_idle", 32'(state0), 32'd0);
        check("post_rst_count", 32'(cnt0), 32'd0);

        // MEM_WAIT=1 build: single FETCH cycle with IL, and a 4-bit counter wrap
        @(posedge clock);
        #1;
        bus1.run = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clock);
            if (state1 == 3'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("w1_reach_fetch", 32'(found), 32'd1);
        check("w1_fetch_il_rcs", 32'(out1), 32'(O_FL));
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i != 0 || k != 0) @(negedge clock);
                check($sformatf("w1_i%0d_k%0d_state", i, k), 32'(state1), 32'(seq1[k]));
                if (k == 3) check($sformatf("w1_i%0d_count", i), 32'(cnt1), 32'(i));
            end
        end
        @(negedge clock);
        check("w1_wrap_count", 32'(cnt1), 32'd0);
        check("w1_no_bubble", 32'(state1), 32'd1);
        bus1.run = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
